pdm_cic_decimator: RTL and testbench

- Converts the 1-bit PDM stream of one MEMS microphone into 19-bit signed PCM samples, using a 3rd-order CIC decimator with R=64.
- Generates the microphone bit clock itself.
- Emits each PCM sample with a one-cycle valid strobe.
- Sits directly upstream of the per-channel delay line: `pcm_data` feeds its `pcm_data` input, and `pcm_valid` is that stage's shift enable.

---
 rtl/pdm_cic_decimator.sv | 131 +++++++++++++
 tb/tb_pdm_cic_decimator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
// PDM microphone front end: generates the mic bit clock and decimates the 1-bit
// stream through a 3rd-order CIC (R=64, M=1) into 19-bit signed PCM samples.
module pdm_cic_decimator #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        pdm_in,
   output logic        pdm_clk,
   output logic [18:0] pcm_data,
   output logic        pcm_valid
);
   localparam int            DW       = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic          pdm_clk_q, pdm_clk_d;
   logic [5:0]    bit_cnt_q, bit_cnt_d;
   logic          dec_flag_q, dec_flag_d;
   logic [1:0]    warm_cnt_q, warm_cnt_d;
   logic [19:0]   i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
   logic [19:0]   d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   logic [18:0]   pcm_data_q, pcm_data_d;
   logic          pcm_valid_q, pcm_valid_d;

   logic          sample_en;
   logic [19:0]   x, c1, c2, c3;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
      div_cnt_d   = div_cnt_q;
      pdm_clk_d   = pdm_clk_q;
      bit_cnt_d   = bit_cnt_q;
      warm_cnt_d  = warm_cnt_q;
      i1_d        = i1_q;
      i2_d        = i2_q;
      i3_d        = i3_q;
      d1_d        = d1_q;
      d2_d        = d2_q;
      d3_d        = d3_q;
      pcm_data_d  = pcm_data_q;
      pcm_valid_d = 1'b0;

      sample_en = (div_cnt_q == DIV_LAST);
      x         = pdm_in ? 20'h0_0001 : 20'hF_FFFF;
      c1        = i3_q - d1_q;
      c2        = c1 - d2_q;
      c3        = c2 - d3_q;

      div_cnt_d  = sample_en ? '0 : div_cnt_q + 1'b1;
      pdm_clk_d  = (div_cnt_d < DIV_HALF);
      dec_flag_d = sample_en && (bit_cnt_q == 6'd63);

      // Integrator chain uses the freshly updated upstream value each step.
      if (sample_en) begin
         i1_d      = i1_q + x;
         i2_d      = i2_q + i1_d;
         i3_d      = i3_q + i2_d;
         bit_cnt_d = bit_cnt_q + 6'd1;
      end

      if (dec_flag_q) begin
         d1_d = i3_q;
         d2_d = c1;
         d3_d = c2;
         // Only full-scale positive (+2^18) is out of 19-bit range.
         if (warm_cnt_q == 2'd3) begin
            pcm_data_d  = (c3 == 20'h4_0000) ? 19'h3_FFFF : c3[18:0];
            pcm_valid_d = 1'b1;
         end else begin
            warm_cnt_d = warm_cnt_q + 2'd1;
         end
      end

      if (!enable) begin
         div_cnt_d   = '0;
         pdm_clk_d   = 1'b0;
         bit_cnt_d   = '0;
         dec_flag_d  = 1'b0;
         warm_cnt_d  = '0;
         i1_d        = '0;
         i2_d        = '0;
         i3_d        = '0;
         d1_d        = '0;
         d2_d        = '0;
         d3_d        = '0;
         pcm_data_d  = '0;
         pcm_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q   <= '0;
         pdm_clk_q   <= 1'b0;
         bit_cnt_q   <= '0;
         dec_flag_q  <= 1'b0;
         warm_cnt_q  <= '0;
         i1_q        <= '0;
         i2_q        <= '0;
         i3_q        <= '0;
         d1_q        <= '0;
         d2_q        <= '0;
         d3_q        <= '0;
         pcm_data_q  <= '0;
         pcm_valid_q <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         pdm_clk_q   <= pdm_clk_d;
         bit_cnt_q   <= bit_cnt_d;
         dec_flag_q  <= dec_flag_d;
         warm_cnt_q  <= warm_cnt_d;
         i1_q        <= i1_d;
         i2_q        <= i2_d;
         i3_q        <= i3_d;
         d1_q        <= d1_d;
         d2_q        <= d2_d;
         d3_q        <= d3_d;
         pcm_data_q  <= pcm_data_d;
         pcm_valid_q <= pcm_valid_d;
      end
   end

   assign pdm_clk   = pdm_clk_q;
   assign pcm_data  = pcm_data_q;
   assign pcm_valid = pcm_valid_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: a convolution-form CIC model (sum of the
// 190-tap impulse response over the sampled bits) checked every cycle.
module tb_pdm_cic_decimator;
   localparam int D  = 4;
   localparam int NB = 8192;

   logic        clk = 1'b0;
   logic        rst_n, enable, pdm_in, en_aux;
   logic        pdm_clk, pcm_valid;
   logic [18:0] pcm_data;
   logic [1:0]  aux_pdm, aux_clk, aux_valid;
   logic [18:0] aux_data0, aux_data1;

   int     errors = 0;
   int     checks = 0;
   int     h [190];
   bit     bits [NB];
   int     mode = 0;
   logic   prev_act = 1'b0;
   int     prev_idx = 0;
   int     cur_idx = -1;
   longint exp_data = 0;
   int     first_strobe = -1, last_strobe = -1, strobe_gap = -1, n_strobes = 0;
   longint obs_data = 0;
   logic [1:0] aux_prev_act = 2'b00;
   int     aux_prev_idx [2];
   longint aux_exp [2];
   int     aux_last [2];

   always #5 clk = ~clk;

   pdm_cic_decimator #(.CLK_DIV(D)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pdm_in(pdm_in),
      .pdm_clk(pdm_clk), .pcm_data(pcm_data), .pcm_valid(pcm_valid));

   pdm_cic_decimator #(.CLK_DIV(2)) u_dut_div2 (
      .clk(clk), .rst_n(rst_n), .enable(en_aux), .pdm_in(aux_pdm[0]),
      .pdm_clk(aux_clk[0]), .pcm_data(aux_data0), .pcm_valid(aux_valid[0]));

   pdm_cic_decimator #(.CLK_DIV(8)) u_dut_div8 (
      .clk(clk), .rst_n(rst_n), .enable(en_aux), .pdm_in(aux_pdm[1]),
      .pdm_clk(aux_clk[1]), .pcm_data(aux_data1), .pcm_valid(aux_valid[1]));

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int aux_div(input int i);
      return (i == 0) ? 2 : 8;
   endfunction

   function automatic logic gen_bit(input int m, input int b);
      case (m)
         0:       return 1'b1;
         1:       return 1'b0;
         default: return (b % 2 == 0);
      endcase
   endfunction

   // Output of decimated frame f: impulse response of (1-z^-64)^3/(1-z^-1)^3
   // applied to the +/-1 input ending at the frame's last bit.
   function automatic longint cic_out(input int f);
      longint y = 0;
      for (int k = 0; k < 190; k++)
         y += longint'(h[k]) * (bits[64*f + 63 - k] ? 1 : -1);
      if (y == 262144) y = 262143;
      return y;
   endfunction

   always @(negedge clk) begin
      int     out_idx, cur, b;
      logic   act, zero, ev;
      int     ad, aout, acur;
      logic   az, aev, aact;
      longint adat;

      zero    = !prev_act || !rst_n;
      out_idx = prev_idx + 1;
      ev      = 1'b0;
      if (zero) exp_data = 0;
      else begin
         ev = (out_idx >= 4*64*D + 1) && (out_idx % (64*D) == 1);
         if (ev) exp_data = cic_out((out_idx - 1) / (64*D) - 1);
      end
      check("pdm_clk", longint'(pdm_clk), zero ? 0 : longint'((out_idx % D) < D/2));
      check("pcm_valid", longint'(pcm_valid), longint'(ev));
      check("pcm_data", longint'($signed(pcm_data)), exp_data);
      if (pcm_valid === 1'b1 && !zero) begin
         if (first_strobe < 0) first_strobe = out_idx;
         else strobe_gap = out_idx - last_strobe;
         last_strobe = out_idx;
         n_strobes++;
         obs_data = longint'($signed(pcm_data));
      end

      act = enable && rst_n;
      cur = (act && prev_act) ? out_idx : 0;
      if (act && !prev_act) begin
         first_strobe = -1; last_strobe = -1; strobe_gap = -1; n_strobes = 0;
      end
      b = cur / D;
      if (!act || mode == 3) pdm_in = 1'($urandom_range(0, 1));
      else pdm_in = gen_bit(mode, b);
      if (act && (cur % D == D - 1) && b < NB) bits[b] = pdm_in;
      prev_act = act;
      prev_idx = cur;
      cur_idx  = act ? cur : -1;

      // Aux instances: pdm_in is 1 only in the expected sampling cycle.
      for (int i = 0; i < 2; i++) begin
         ad   = aux_div(i);
         az   = !aux_prev_act[i] || !rst_n;
         aout = aux_prev_idx[i] + 1;
         aev  = !az && (aout >= 256*ad + 1) && (aout % (64*ad) == 1);
         if (az) aux_exp[i] = 0;
         else if (aev) aux_exp[i] = 262143;
         adat = (i == 0) ? longint'($signed(aux_data0)) : longint'($signed(aux_data1));
         check($sformatf("div%0d pdm_clk", ad), longint'(aux_clk[i]),
               az ? 0 : longint'((aout % ad) < ad/2));
         check($sformatf("div%0d pcm_valid", ad), longint'(aux_valid[i]), longint'(aev));
         check($sformatf("div%0d pcm_data", ad), adat, aux_exp[i]);
         if (aux_valid[i] === 1'b1 && !az) begin
            if (aux_last[i] >= 0)
               check($sformatf("div%0d gap", ad), aout - aux_last[i], (ad == 2) ? 128 : 512);
            aux_last[i] = aout;
         end
         aact = en_aux && rst_n;
         acur = (aact && aux_prev_act[i]) ? aout : 0;
         if (aact && !aux_prev_act[i]) aux_last[i] = -1;
         aux_pdm[i]      = aact && (acur % ad == ad - 1);
         aux_prev_act[i] = aact;
         aux_prev_idx[i] = acur;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic run_phase(input int m, input int n);
      enable = 1'b0;
      step(10);
      mode   = m;
      enable = 1'b1;
      step(n);
   endtask

   initial begin
      int sum;
      rst_n = 1'b0; enable = 1'b0; en_aux = 1'b0; pdm_in = 1'b0; aux_pdm = 2'b00;
      for (int i = 0; i < 2; i++) begin
         aux_prev_idx[i] = 0; aux_exp[i] = 0; aux_last[i] = -1;
      end

      foreach (h[k]) h[k] = 0;
      for (int a = 0; a < 64; a++)
         for (int b = 0; b < 64; b++)
            for (int c = 0; c < 64; c++)
               h[a + b + c]++;
      sum = 0;
      foreach (h[k]) sum += h[k];
      check("h[0]", h[0], 1);
      check("h[2]", h[2], 6);
      check("h[94]", h[94], 3072);
      check("h[189]", h[189], 1);
      check("h sum", sum, 262144);
      for (int k = 0; k < 256; k++) bits[k] = 1'b1;
      check("model ones", cic_out(3), 262143);
      for (int k = 0; k < 256; k++) bits[k] = 1'b0;
      check("model zeros", cic_out(3), -262144);
      bits[161] = 1'b1;
      check("model impulse", cic_out(3), -256000);
      for (int k = 0; k < 256; k++) bits[k] = (k % 2 == 0);
      check("model alt", cic_out(3), 0);

      step(1);
      check("reset pcm_data", longint'(pcm_data), 0);
      check("reset pcm_valid", longint'(pcm_valid), 0);
      check("reset pdm_clk", longint'(pdm_clk), 0);
      step(2);
      rst_n = 1'b1;
      step(5);

      // All ones; drop enable in the S+1 cycle of frame 5.
      mode = 0; enable = 1'b1; en_aux = 1'b1;
      for (int n = 0; n < 3000 && cur_idx != 1535; n++) step(1);
      check("ones reached frame5 S", cur_idx, 1535);
      enable = 1'b0;
      check("ones first strobe", first_strobe, 1025);
      check("ones gap", strobe_gap, 256);
      check("ones strobes", n_strobes, 2);
      check("ones data", obs_data, 262143);
      step(1);
      enable = 1'b1;
      step(3);

      run_phase(1, 1025 + 256*20 + 5);
      check("zeros first strobe", first_strobe, 1025);
      check("zeros strobes", n_strobes, 21);
      check("zeros data", obs_data, -262144);

      run_phase(2, 1025 + 256*5 + 5);
      check("alt first strobe", first_strobe, 1025);
      check("alt strobes", n_strobes, 6);
      check("alt data", obs_data, 0);

      run_phase(3, 1025 + 256*50 + 5);
      check("rand first strobe", first_strobe, 1025);
      check("rand strobes", n_strobes, 51);

      rst_n = 1'b0;
      #1;
      check("async rst pcm_data", longint'(pcm_data), 0);
      check("async rst pcm_valid", longint'(pcm_valid), 0);
      check("async rst pdm_clk", longint'(pdm_clk), 0);
      check("async rst div8 data", longint'(aux_data1), 0);
      step(5);
      rst_n = 1'b1;
      step(1025 + 10);
      check("post-reset first strobe", first_strobe, 1025);
      check("post-reset strobes", n_strobes, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
